// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing source with pixel coordinates,
// a visible-area flag and hs/vs delayed to line up with registered colour.
//
// Ports:
//   vga_clk     in   pixel clock (or a faster clock qualified by pix_en)
//   reset       in   synchronous, active-high
//   pix_en      in   advance one pixel on this edge
//   DrawX/DrawY out  registered column/row of the current pixel
//   blank       out  1 = (DrawX,DrawY) lies in the visible area
//   hs/vs       out  sync outputs, SYNC_DELAY enabled cycles behind the counters
//   line_start  out  high while sitting on DrawX=0 reached by a line wrap
//   frame_start out  high while sitting on (0,0) reached by a frame wrap

module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic ACT   = SYNC_POL;
    localparam logic INACT = ~SYNC_POL;

    // {hs, vs} pair carried through the delay line
    typedef logic [1:0] sync_t;
    localparam sync_t SYNC_IDLE = {INACT, INACT};

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       blank_q, blank_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic       h_wrap, v_wrap;
    sync_t      raw_d;

    // Stage 0 holds the raw decode; stage SYNC_DELAY drives the pins.
    sync_t [SYNC_DELAY:0] sync_q, sync_d;

    always_comb begin
        h_wrap  = (hc_q == H_LAST);
        v_wrap  = (vc_q == V_LAST);
        hc_d    = hc_q;
        vc_d    = vc_q;
        blank_d = blank_q;
        ls_d    = ls_q;
        fs_d    = fs_q;
        if (pix_en) begin
            hc_d = h_wrap ? 10'd0 : hc_q + 10'd1;
            if (h_wrap) begin
                vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
            end
            // Decoded from the next counter values so they register
            // alongside DrawX/DrawY.
            blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
            ls_d    = h_wrap;
            fs_d    = h_wrap && v_wrap;
        end
        raw_d[1] = (hc_d >= HS_BEG && hc_d < HS_END) ? ACT : INACT;
        raw_d[0] = (vc_d >= VS_BEG && vc_d < VS_END) ? ACT : INACT;
    end

    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            always_comb begin
                sync_d = pix_en ? raw_d : sync_q;
            end
        end else begin : g_dly
            always_comb begin
                sync_d = sync_q;
                if (pix_en) begin
                    sync_d = {sync_q[SYNC_DELAY-1:0], raw_d};
                end
            end
        end
    endgenerate

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q    <= '0;
            vc_q    <= '0;
            blank_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            sync_q  <= {(SYNC_DELAY + 1){SYNC_IDLE}};
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            blank_q <= blank_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            sync_q  <= sync_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = blank_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign hs          = sync_q[SYNC_DELAY][1];
    assign vs          = sync_q[SYNC_DELAY][0];

endmodule
